// File: rtl/control_sequencer.sv
// Parametrised instruction sequencer for the processor control unit.
// It walks FETCH/DECODE/execute states and drives the PC, data memory, register file and ALU controls.
module control_sequencer #(
  parameter int IW        = 16,
  parameter int OPW       = 4,
  parameter int DAW       = 8,
  parameter int RAW       = 4,
  parameter int ASW       = 3,
  parameter int LOAD_WAIT = 1
) (
  input  logic           Clk,
  input  logic           ResetN,
  input  logic [IW-1:0]  IR,
  input  logic           Zero,
  input  logic           Resume,
  output logic           PC_clr,
  output logic           PC_up,
  output logic           PC_ld,
  output logic [DAW-1:0] PC_addr,
  output logic           IR_ld,
  output logic [DAW-1:0] D_addr,
  output logic           D_wr,
  output logic           RF_s,
  output logic           RF_W_en,
  output logic [RAW-1:0] RF_W_addr,
  output logic [RAW-1:0] RF_Ra_addr,
  output logic [RAW-1:0] RF_Rb_addr,
  output logic [ASW-1:0] ALU_s0,
  output logic           Illegal,
  output logic           Halted,
  output logic [3:0]     CurrentState
);

  if ((OPW + DAW + RAW > IW) || (OPW + 3 * RAW > IW)) begin : g_bad_fields
    $error("control_sequencer: instruction fields do not fit in IW");
  end
  if (LOAD_WAIT < 1) begin : g_bad_wait
    $error("control_sequencer: LOAD_WAIT must be at least 1");
  end
  if (ASW < 2) begin : g_bad_asw
    $error("control_sequencer: ASW must be at least 2 to encode sub");
  end

  localparam int CW = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_NOOP      = 4'd3,
    S_STORE     = 4'd4,
    S_LOAD_WAIT = 4'd5,
    S_LOAD_WR   = 4'd6,
    S_ADD       = 4'd7,
    S_SUB       = 4'd8,
    S_JMPZ      = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  state_t         state;
  logic [CW-1:0]  wait_cnt;

  logic [OPW-1:0] opcode;
  logic [RAW-1:0] ra;
  logic [RAW-1:0] rb;
  logic [RAW-1:0] rw;
  logic [DAW-1:0] sa;
  logic [DAW-1:0] la;

  assign opcode = IR[IW-1 -: OPW];
  assign ra     = IR[IW-OPW-1 -: RAW];
  assign rb     = IR[IW-OPW-RAW-1 -: RAW];
  assign rw     = IR[RAW-1:0];
  assign sa     = IR[DAW-1:0];
  assign la     = IR[IW-OPW-1 -: DAW];

  assign CurrentState = state;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state    <= S_INIT;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OPW'(0): state <= S_NOOP;
            OPW'(1): state <= S_STORE;
            OPW'(2): state <= S_LOAD_WAIT;
            OPW'(3): state <= S_ADD;
            OPW'(4): state <= S_SUB;
            OPW'(5): state <= S_HALT;
            OPW'(6): state <= S_JMPZ;
            default: state <= S_NOOP;
          endcase
        end
        // The wait counter only advances here, so it is always zero on entry.
        S_LOAD_WAIT: begin
          if (wait_cnt == CW'(LOAD_WAIT - 1)) begin
            wait_cnt <= '0;
            state    <= S_LOAD_WR;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_HALT:   if (Resume) state <= S_FETCH;
        S_NOOP, S_STORE, S_LOAD_WR, S_ADD, S_SUB, S_JMPZ: state <= S_FETCH;
        default:  state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    PC_ld      = 1'b0;
    PC_addr    = '0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = '0;
    Illegal    = 1'b0;
    Halted     = 1'b0;
    case (state)
      S_INIT:   PC_clr = 1'b1;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      S_DECODE: Illegal = (opcode > OPW'(6));
      S_STORE: begin
        D_addr     = sa;
        D_wr       = 1'b1;
        RF_Ra_addr = ra;
      end
      S_LOAD_WAIT, S_LOAD_WR: begin
        D_addr    = la;
        RF_s      = 1'b1;
        RF_W_addr = rw;
        RF_W_en   = (state == S_LOAD_WR);
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ra;
        RF_Rb_addr = rb;
        RF_W_addr  = rw;
        RF_W_en    = 1'b1;
        ALU_s0     = (state == S_ADD) ? ASW'(1) : ASW'(2);
      end
      // Zero comes straight from this cycle's ALU result, so the jump decision is not registered.
      S_JMPZ: begin
        RF_Ra_addr = ra;
        PC_addr    = sa;
        PC_ld      = Zero;
      end
      S_HALT:   Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with LOAD_WAIT=3: reset, ADD, LOAD (+abort), JMPZ, illegal, STORE, HALT.
module tb_control_sequencer;

  logic        Clk;
  logic        ResetN;
  logic [15:0] IR;
  logic        Zero;
  logic        Resume;
  logic        PC_clr, PC_up, PC_ld, IR_ld, D_wr, RF_s, RF_W_en, Illegal, Halted;
  logic [7:0]  PC_addr, D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, CurrentState;
  logic [2:0]  ALU_s0;

  int n_tests = 0;
  int n_fail  = 0;

  control_sequencer #(.IW(16), .OPW(4), .DAW(8), .RAW(4), .ASW(3), .LOAD_WAIT(3)) dut (
    .Clk(Clk), .ResetN(ResetN), .IR(IR), .Zero(Zero), .Resume(Resume),
    .PC_clr(PC_clr), .PC_up(PC_up), .PC_ld(PC_ld), .PC_addr(PC_addr), .IR_ld(IR_ld),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .ALU_s0(ALU_s0),
    .Illegal(Illegal), .Halted(Halted), .CurrentState(CurrentState)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    ResetN = 1'b0;
    IR     = 16'h0000;
    Zero   = 1'b0;
    Resume = 1'b0;
    #1;
    check("rst_state", 32'(CurrentState), 32'd0);
    check("rst_pc_clr", 32'(PC_clr), 32'd1);
    check("rst_ir_ld", 32'(IR_ld), 32'd0);
    step();
    step();
    check("rst_hold_state", 32'(CurrentState), 32'd0);
    ResetN = 1'b1;
    step();
    check("fetch_state", 32'(CurrentState), 32'd1);
    check("fetch_ir_ld", 32'(IR_ld), 32'd1);
    check("fetch_pc_up", 32'(PC_up), 32'd1);
    check("fetch_pc_clr", 32'(PC_clr), 32'd0);
    check("fetch_pc_ld", 32'(PC_ld), 32'd0);

    // ADD r5 <= r1 + r2
    IR = 16'h3125;
    step();
    check("add_decode", 32'(CurrentState), 32'd2);
    check("add_decode_ill", 32'(Illegal), 32'd0);
    step();
    check("add_state", 32'(CurrentState), 32'd7);
    check("add_ra", 32'(RF_Ra_addr), 32'd1);
    check("add_rb", 32'(RF_Rb_addr), 32'd2);
    check("add_wa", 32'(RF_W_addr), 32'd5);
    check("add_wen", 32'(RF_W_en), 32'd1);
    check("add_alu", 32'(ALU_s0), 32'd1);
    check("add_rfs", 32'(RF_s), 32'd0);
    step();
    check("add_back_fetch", 32'(CurrentState), 32'd1);

    // LOAD r7 <= mem[AB], three wait cycles then the write cycle
    IR = 16'h2AB7;
    step();
    check("ld_decode", 32'(CurrentState), 32'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("ld_state%0d", i), 32'(CurrentState), (i < 3) ? 32'd5 : 32'd6);
      check($sformatf("ld_daddr%0d", i), 32'(D_addr), 32'hAB);
      check($sformatf("ld_rfs%0d", i), 32'(RF_s), 32'd1);
      check($sformatf("ld_wa%0d", i), 32'(RF_W_addr), 32'd7);
      check($sformatf("ld_wen%0d", i), 32'(RF_W_en), (i == 3) ? 32'd1 : 32'd0);
    end
    step();
    check("ld_back_fetch", 32'(CurrentState), 32'd1);

    // LOAD aborted by reset in the middle of the wait
    step();
    step();
    step();
    check("ab_in_wait", 32'(CurrentState), 32'd5);
    ResetN = 1'b0;
    #1;
    check("ab_state", 32'(CurrentState), 32'd0);
    check("ab_pc_clr", 32'(PC_clr), 32'd1);
    check("ab_wen", 32'(RF_W_en), 32'd0);
    check("ab_rfs", 32'(RF_s), 32'd0);
    step();
    check("ab_hold_wen", 32'(RF_W_en), 32'd0);
    ResetN = 1'b1;
    step();
    check("ab_fetch", 32'(CurrentState), 32'd1);
    check("ab_fetch_wen", 32'(RF_W_en), 32'd0);

    // JMPZ taken, then Zero dropping inside the same cycle
    IR   = 16'h6340;
    Zero = 1'b1;
    step();
    step();
    check("jz_state", 32'(CurrentState), 32'd9);
    check("jz_pc_ld", 32'(PC_ld), 32'd1);
    check("jz_pc_addr", 32'(PC_addr), 32'h40);
    check("jz_ra", 32'(RF_Ra_addr), 32'd3);
    check("jz_alu", 32'(ALU_s0), 32'd0);
    check("jz_pc_up", 32'(PC_up), 32'd0);
    Zero = 1'b0;
    #1;
    check("jz_zero_drop", 32'(PC_ld), 32'd0);
    step();
    check("jz_fetch", 32'(CurrentState), 32'd1);

    // JMPZ not taken
    step();
    step();
    check("jn_state", 32'(CurrentState), 32'd9);
    check("jn_pc_ld", 32'(PC_ld), 32'd0);
    step();
    check("jn_fetch", 32'(CurrentState), 32'd1);

    // Undefined opcode
    IR = 16'hF000;
    step();
    check("il_decode", 32'(CurrentState), 32'd2);
    check("il_flag", 32'(Illegal), 32'd1);
    step();
    check("il_noop", 32'(CurrentState), 32'd3);
    check("il_flag_gone", 32'(Illegal), 32'd0);
    check("il_dwr", 32'(D_wr), 32'd0);
    check("il_wen", 32'(RF_W_en), 32'd0);
    step();
    check("il_fetch", 32'(CurrentState), 32'd1);

    // STORE rA -> mem[5C]
    IR = 16'h1A5C;
    step();
    step();
    check("st_state", 32'(CurrentState), 32'd4);
    check("st_dwr", 32'(D_wr), 32'd1);
    check("st_daddr", 32'(D_addr), 32'h5C);
    check("st_ra", 32'(RF_Ra_addr), 32'hA);
    check("st_wen", 32'(RF_W_en), 32'd0);
    step();
    check("st_fetch", 32'(CurrentState), 32'd1);

    // HALT for ten cycles, then resume
    IR = 16'h5000;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("ht_halted%0d", i), 32'(Halted), 32'd1);
      check($sformatf("ht_state%0d", i), 32'(CurrentState), 32'd10);
      if (i < 9) step();
    end
    Resume = 1'b1;
    step();
    check("ht_resume_state", 32'(CurrentState), 32'd1);
    check("ht_resume_halted", 32'(Halted), 32'd0);
    IR = 16'h0000;
    step();
    step();
    check("ht_held_resume", 32'(CurrentState), 32'd3);
    Resume = 1'b0;
    step();
    check("end_fetch", 32'(CurrentState), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
